regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter: NREG, 32, number of general-purpose registers; the address width is 5 bits.
REQ-002 Parameter: DW, 32, register data width in bits.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 we  in  1  writeback enable; it is qualified by the writeback-select mux output being valid.
REQ-007 waddr  in  5  writeback destination register (rd/rt/$31).
REQ-008 wdata  in  32  writeback data, taken from the writeback-select mux.
REQ-009 raddr1  in  5  read port 1 address (rs).
REQ-010 raddr2  in  5  read port 2 address (rt).
REQ-011 rdata1  out  32  read port 1 data.
REQ-012 rdata2  out  32  read port 2 data.
REQ-013 busy_set  in  1  marks a register as the target of a pending long-latency result (div, cp0, load).
REQ-014 busy_addr  in  5  register marked by busy_set.
REQ-015 busy1  out  1  raddr1 has a pending write that is not satisfied this cycle.
REQ-016 busy2  out  1  raddr2 has a pending write that is not satisfied this cycle.

Function
REQ-017 Storage: the register array is NREG x DW; register 0 reads 0 always and is never written or marked busy.
REQ-018 Write: at a rising edge with we=1 and waddr!=0, reg[waddr] takes wdata; the write has 1-cycle latency into the array.
REQ-019 Read: rdata1/rdata2 are combinational from raddr1/raddr2 with zero-cycle latency.
REQ-020 Bypass: when we=1, waddr==raddrN and raddrN!=0, rdataN equals wdata in the same cycle.
REQ-021 Both read ports may address the same register; each port shall return identical data.
REQ-022 Scoreboard: there is one busy bit per register; busy_set=1 with busy_addr!=0 sets busy[busy_addr] at the edge.
REQ-023 Clear: a write with we=1 and waddr!=0 clears busy[waddr] at the edge.
REQ-024 Simultaneous set and write to the same address: set wins, so busy stays 1 (a new pending op supersedes the old one); the data write still occurs.
REQ-025 Simultaneous set and write to different addresses: both take effect independently.
REQ-026 busyN = busy[raddrN] AND NOT (we AND waddr==raddrN); busyN = 0 when raddrN = 0.
REQ-027 A busy_set issued in cycle t affects busyN from cycle t+1 onward; there is no same-cycle set-forwarding.
REQ-028 we=1 with waddr=0 is a legal no-op and shall not raise an error.

Reset
REQ-029 When rst=1 at an edge, all registers become 0 and all busy bits become 0.
REQ-030 Reset dominates we and busy_set in the same cycle.
REQ-031 The read path stays combinational during reset, so rdata reflects the pre-edge contents until the edge; outputs are 0 after the reset edge.
REQ-032 Reset mid-operation discards all pending busy marks; a later write to a formerly busy register behaves as a normal write.

Structure
REQ-033 NREG, DW, the address width and the register-0 index constant belong in the shared CPU package, next to the writeback-select codes.
REQ-034 Hierarchy: a single module with no sub-modules; the scoreboard is an inline 32-bit vector.

Verification
REQ-035 Reset, then read addresses 0..31 -> all rdata = 0, all busy = 0.
REQ-036 we=1, waddr=5, wdata=0xDEADBEEF, raddr1=5 in the same cycle -> rdata1 = 0xDEADBEEF (bypass); the next cycle with we=0 -> still 0xDEADBEEF.
REQ-037 we=1, waddr=0, wdata=0xFFFFFFFF -> rdata1 with raddr1=0 = 0 both in the same cycle and in the next cycle.
REQ-038 busy_set, addr=8; next cycle raddr2=8 -> busy2 = 1; then we=1, waddr=8, wdata=0x12 -> busy2 = 0 and rdata2 = 0x12 in the same cycle; busy stays cleared after.
REQ-039 busy_set and write on addr=9 in the same cycle -> reg9 updated and busy[9] = 1 in the next cycle.
REQ-040 Write reg3=0x55 and set busy[3], then rst=1 together with we=1, waddr=3 -> reg3 = 0 and busy1 = 0 for raddr1=3.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared CPU constants: register file geometry, register-0 index and writeback-select codes.
// Constants only, so there is no latency or backpressure.
package regfile_pkg;

    localparam int NREG = 32;
    localparam int DW   = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = '0;
    localparam logic [AW-1:0] REG_LINK = 5'd31;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2,
        WB_CP0  = 2'd3
    } wb_sel_e;

endpackage

// File: rtl/regfile.sv
// 2R1W register file with a write-to-read bypass and a per-register pending-result scoreboard.
// Reads are combinational and writes land at the next edge; there is no backpressure, and the busy outputs tell the pipeline when to stall.
module regfile
    import regfile_pkg::*;
#(
    parameter int NREG_P = NREG,
    parameter int DW_P   = DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [DW_P-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [DW_P-1:0] rdata1,
    output logic [DW_P-1:0] rdata2,
    input  logic            busy_set,
    input  logic [AW-1:0]   busy_addr,
    output logic            busy1,
    output logic            busy2
);

    logic [DW_P-1:0]   regs_q [NREG_P];
    logic [NREG_P-1:0] busy_q;
    logic [NREG_P-1:0] busy_d;
    logic              wr_vld;
    logic              hit1;
    logic              hit2;

    assign wr_vld = we && (waddr != REG_ZERO);
    assign hit1   = wr_vld && (waddr == raddr1);
    assign hit2   = wr_vld && (waddr == raddr2);

    always_comb begin
        busy_d = busy_q;
        if (wr_vld) begin
            busy_d[waddr] = 1'b0;
        end
        // The set is applied last: a new pending op supersedes the result that is landing now.
        if (busy_set && (busy_addr != REG_ZERO)) begin
            busy_d[busy_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG_P; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_vld) begin
                regs_q[waddr] <= wdata;
            end
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        busy1  = 1'b0;
        busy2  = 1'b0;
        if (raddr1 != REG_ZERO) begin
            rdata1 = hit1 ? wdata : regs_q[raddr1];
            busy1  = busy_q[raddr1] && !hit1;
        end
        if (raddr2 != REG_ZERO) begin
            rdata2 = hit2 ? wdata : regs_q[raddr2];
            busy2  = busy_q[raddr2] && !hit2;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Randomised and directed checks of regfile against an array-based model of the architectural registers and pending marks.
module tb_regfile;
    import regfile_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic          busy_set;
    logic [AW-1:0] busy_addr;
    logic          busy1;
    logic          busy2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] m_reg  [32];
    bit            m_busy [32];

    regfile dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .busy1     (busy1),
        .busy2     (busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural view: r0 is 0, a value being written is visible at once, and a mark being cleared is no longer busy.
    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (we && waddr == a) return wdata;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        return m_busy[a] && !(we && waddr == a);
    endfunction

    // Wait to the opposite edge and compare every output with the model.
    task automatic settle();
        @(negedge clk);
        if (!rst) begin
            chk("model_rdata1", rdata1, exp_rd(raddr1));
            chk("model_rdata2", rdata2, exp_rd(raddr2));
            chk("model_busy1", {31'b0, busy1}, {31'b0, exp_busy(raddr1)});
            chk("model_busy2", {31'b0, busy2}, {31'b0, exp_busy(raddr2)});
        end
    endtask

    // Advance one edge, apply the same edge to the model, then step off the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we && waddr != 0) begin
                m_reg[waddr]  = wdata;
                m_busy[waddr] = 1'b0;
            end
            if (busy_set && busy_addr != 0) m_busy[busy_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        we = 1'b0; waddr = '0; wdata = '0;
        busy_set = 1'b0; busy_addr = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        raddr1 = '0; raddr2 = '0;
        tick(); tick();
        rst = 1'b0;

        // After reset every register reads zero and nothing is busy.
        for (int a = 0; a < 32; a++) begin
            raddr1 = AW'(a);
            raddr2 = AW'(31 - a);
            settle();
            chk("reset_rdata1", rdata1, 32'h0);
            chk("reset_rdata2", rdata2, 32'h0);
            chk("reset_busy1", {31'b0, busy1}, 32'h0);
            chk("reset_busy2", {31'b0, busy2}, 32'h0);
            tick();
        end

        // Same-cycle bypass, then the stored value.
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr1 = 5'd5; raddr2 = 5'd5;
        settle();
        chk("bypass_rdata1", rdata1, 32'hDEADBEEF);
        chk("bypass_rdata2", rdata2, 32'hDEADBEEF);
        tick();
        idle();
        settle();
        chk("stored_rdata1", rdata1, 32'hDEADBEEF);
        tick();

        // Writes to r0 are ignored, including the bypass.
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0;
        settle();
        chk("r0_same_cycle", rdata1, 32'h0);
        tick();
        idle();
        settle();
        chk("r0_next_cycle", rdata1, 32'h0);
        tick();

        // Busy mark: not forwarded in the set cycle, cleared by the write in the write cycle.
        busy_set = 1'b1; busy_addr = 5'd8; raddr2 = 5'd8;
        settle();
        chk("busy_no_fwd", {31'b0, busy2}, 32'h0);
        tick();
        idle();
        settle();
        chk("busy_set", {31'b0, busy2}, 32'h1);
        tick();
        we = 1'b1; waddr = 5'd8; wdata = 32'h12;
        settle();
        chk("busy_clear_same", {31'b0, busy2}, 32'h0);
        chk("busy_clear_data", rdata2, 32'h12);
        tick();
        idle();
        settle();
        chk("busy_stays_clear", {31'b0, busy2}, 32'h0);
        chk("busy_clear_stored", rdata2, 32'h12);
        tick();

        // Set and write to one address: the data lands and the mark survives.
        busy_set = 1'b1; busy_addr = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h99; raddr1 = 5'd9;
        tick();
        idle();
        settle();
        chk("setwin_data", rdata1, 32'h99);
        chk("setwin_busy", {31'b0, busy1}, 32'h1);
        tick();

        // Reset dominates a write and a set to the same register.
        we = 1'b1; waddr = 5'd3; wdata = 32'h55; busy_set = 1'b1; busy_addr = 5'd3;
        tick();
        idle();
        raddr1 = 5'd3;
        settle();
        chk("pre_rst_data", rdata1, 32'h55);
        chk("pre_rst_busy", {31'b0, busy1}, 32'h1);
        rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h77; busy_set = 1'b1; busy_addr = 5'd3;
        tick();
        rst = 1'b0;
        idle();
        settle();
        chk("rst_dom_data", rdata1, 32'h0);
        chk("rst_dom_busy", {31'b0, busy1}, 32'h0);
        tick();
        we = 1'b1; waddr = 5'd3; wdata = 32'hAB;
        tick();
        idle();
        settle();
        chk("post_rst_write", rdata1, 32'hAB);
        chk("post_rst_busy", {31'b0, busy1}, 32'h0);
        tick();

        // Random traffic; a narrow address range half the time forces frequent collisions.
        for (int c = 0; c < 3000; c++) begin
            int hi;
            hi        = ($urandom_range(0, 1) == 0) ? 3 : 31;
            rst       = ($urandom_range(0, 199) == 0);
            we        = ($urandom_range(0, 1) == 1);
            waddr     = AW'($urandom_range(0, hi));
            wdata     = $urandom;
            busy_set  = ($urandom_range(0, 2) == 0);
            busy_addr = AW'($urandom_range(0, hi));
            raddr1    = AW'($urandom_range(0, hi));
            raddr2    = ($urandom_range(0, 3) == 0) ? raddr1 : AW'($urandom_range(0, hi));
            settle();
            if (!rst) chk("same_addr_ports", rdata1, (raddr1 == raddr2) ? rdata2 : rdata1);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, got running, expected done");
        $fatal(1);
    end

endmodule
